program_loader: RTL and testbench
=================================

# program_loader

Byte-stream program loader for the TINY RISC core. It receives a framed program image over a valid/ready byte interface and assembles big-endian 32-bit instruction words. It writes each word into the instruction memory through that memory's write port, which is the `writeAddr`/`writeData`/`wr` side, while the fetch unit reads the same memory through its read port. It holds the core's fetch unit in clear until a complete, checksum-valid image is in memory.

## Interface

Parameters:
- `MAX_WORDS`, 256: instruction memory depth in words. The LEN field encodes 1..256; 0 means 256.
- `ADDR_W`, 32: width of `writeAddr`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  loader accepts a byte; a transfer occurs on a rising edge with `in_valid && in_ready`
- `writeAddr`  out  ADDR_W  byte address of the word being written, always word index × 4
- `writeData`  out  32  assembled instruction word
- `wr`  out  1  instruction-memory write enable; one cycle per word
- `core_hold`  out  1  drives the fetch unit's `clrPC`/`clrInst`; high while the image is absent or invalid
- `done`  out  1  frame complete (good or bad)
- `err`  out  1  checksum mismatch on the last frame
- `word_count`  out  9  number of words written in the current or last frame

## Operation

- Frame format is `LEN` (1 byte), then 4×LEN data bytes sent MSB first per word, then `CSUM` (1 byte).
- `CSUM` is the XOR of all data bytes. `LEN` is not included in the checksum.
- States and transitions:
  - IDLE: `start` → LEN.
  - LEN: on a byte transfer, latch the word total (0 → 256), clear the byte index, word index and running XOR, then → DATA.
  - DATA: each transfer shifts the byte into the word register (`{word[23:0], in_data}`) and XORs it into the running checksum. The 4th byte of a word → WRITE.
  - WRITE: `wr`=1 for one cycle, then increment `word_count`. If words remain → DATA; if this was the last word → CSUM.
  - CSUM: on a byte transfer, compare the byte with the running XOR and set `err` on mismatch, then → DONE.
  - DONE: `start` → LEN. Clear `err`, `done` and `word_count` on that edge.
- `in_ready` = 1 in LEN, DATA and CSUM. It is 0 in IDLE, WRITE and DONE.
- `start` is ignored in LEN, DATA, WRITE and CSUM.
- `core_hold` = !(`done` && !`err`). A bad image keeps the core held.
- Words already written before a checksum error remain in memory. No rollback is performed.
- Word index width is 9 bits. The maximum `writeAddr` is 0x3FC, and no wrap occurs within a frame.

## Timing

- Reset (asynchronous, `reset`=0) forces the following immediately:
  - state = IDLE
  - `wr`=0, `in_ready`=0, `done`=0, `err`=0
  - `writeAddr`=0, `writeData`=0, `word_count`=0
  - `core_hold`=1
- Reset mid-frame abandons the frame. `wr` drops without waiting for a clock edge.
- Latency: if the 4th byte of a word transfers on edge k, then `wr`, `writeAddr` and `writeData` are valid from k until k+1, and memory captures the word on edge k+1.
- The earliest next data byte transfers on edge k+2. Sustained throughput is 4 bytes per 5 cycles.
- `writeAddr` and `writeData` hold their last values outside WRITE.
- The upstream source may hold `in_valid` high continuously. Bytes are consumed only when `in_ready`=1, and `in_data` must be held until the transfer.
- `start` arriving together with `in_valid`: no byte is consumed in that cycle, and the first transfer occurs in LEN at the earliest on the next edge.
- On the CSUM transfer edge, `done` rises and `err` is set if the checksum mismatches, both registered on that edge. `core_hold` falls combinationally from them.

## Test plan

- **Reset:** assert `reset`=0 mid-cycle → all outputs take their reset values asynchronously, with `core_hold`=1 and `in_ready`=0.
- **Good frame:** `start`, then stream 02 11 22 33 44 55 66 77 88 88 back-to-back →
  - `wr` pulses write 0x11223344 to address 0 and 0x55667788 to address 4
  - `done`=1, `err`=0, `core_hold`=0, `word_count`=2
  - a downstream fetch from PC 0 returns 0x11223344
- **Bad checksum:** same frame but `CSUM`=0x00 → both words are written, `done`=1, `err`=1, `core_hold`=1. A following `start` clears `err`.
- **Back-pressure:** hold `in_valid`=1 with a new byte offered every cycle → `in_ready`=0 for exactly one cycle after each 4th byte, no byte is lost or duplicated, and the data written matches the stream.
- **Full depth:** LEN=0x00 with 1024 data bytes (word i = i) → 256 writes, last `writeAddr`=0x3FC, `word_count`=256.
- **Reset during DATA:** reset after 6 bytes → `wr`=0 immediately, state IDLE. Then run a fresh `start` and a good frame → that frame loads correctly.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: receives a LEN/data/CSUM byte frame and writes big-endian words into instruction memory,
// holding the core in clear until a checksum-valid image has been loaded.
module program_loader #(
    parameter int MAX_WORDS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [31:0]       writeData,
    output logic              wr,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [8:0]        word_count
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE} loaderState;

    loaderState  state;
    logic [8:0]  wordTotal;
    logic [1:0]  byteIdx;
    logic [7:0]  runXor;
    logic [23:0] shiftWord;
    logic        take;
    logic [8:0]  nextCount;

    assign take      = in_valid && in_ready;
    assign nextCount = word_count + 9'd1;
    assign core_hold = !(done && !err);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            wr         <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            writeAddr  <= '0;
            writeData  <= '0;
            word_count <= '0;
            wordTotal  <= '0;
            byteIdx    <= '0;
            runXor     <= '0;
            shiftWord  <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= LEN;
                    in_ready   <= 1'b1;
                    done       <= 1'b0;
                    err        <= 1'b0;
                    word_count <= '0;
                end
                LEN: if (take) begin
                    wordTotal  <= (in_data == 8'd0) ? 9'(MAX_WORDS) : {1'b0, in_data};
                    byteIdx    <= '0;
                    word_count <= '0;
                    runXor     <= '0;
                    state      <= DATA;
                end
                DATA: if (take) begin
                    shiftWord <= {shiftWord[15:0], in_data};
                    runXor    <= runXor ^ in_data;
                    byteIdx   <= byteIdx + 2'd1;
                    // the 4th byte completes the word straight from the shifter, so the write starts this edge
                    if (byteIdx == 2'd3) begin
                        state     <= WRITE;
                        in_ready  <= 1'b0;
                        wr        <= 1'b1;
                        writeData <= {shiftWord, in_data};
                        writeAddr <= ADDR_W'({word_count, 2'b00});
                    end
                end
                WRITE: begin
                    wr         <= 1'b0;
                    in_ready   <= 1'b1;
                    word_count <= nextCount;
                    state      <= (nextCount == wordTotal) ? CSUM : DATA;
                end
                CSUM: if (take) begin
                    err      <= in_data != runXor;
                    done     <= 1'b1;
                    in_ready <= 1'b0;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames against a small instruction-memory model.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] writeAddr;
    logic [31:0] writeData;
    logic        wr;
    logic        core_hold;
    logic        done;
    logic        err;
    logic [8:0]  word_count;

    program_loader #(.MAX_WORDS(256), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .writeAddr(writeAddr), .writeData(writeData), .wr(wr),
        .core_hold(core_hold), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int stalls;
    int wrCount = 0;
    int base;
    logic [31:0] mem [256];
    logic [31:0] logAddr [512];
    logic [31:0] logData [512];
    logic [31:0] frameWords [256];

    // wr is high for one full cycle, so exactly one falling edge sees each write
    always @(negedge clk) if (wr) begin
        mem[writeAddr[9:2]] <= writeData;
        logAddr[wrCount % 512] <= writeAddr;
        logData[wrCount % 512] <= writeData;
        wrCount <= wrCount + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) begin
            stalls++;
            @(posedge clk); #1;
        end
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic runFrame(input int n, input logic [7:0] lenByte, input bit zeroCsum);
        logic [7:0] x;
        x = 8'd0;
        base = wrCount;
        in_data  = lenByte;
        in_valid = 1'b1;
        check("ready_at_start", {31'd0, in_ready}, 32'd0);
        pulseStart();
        stalls = 0;
        sendByte(lenByte);
        for (int w = 0; w < n; w++)
            for (int k = 3; k >= 0; k--) begin
                x = x ^ frameWords[w][k*8 +: 8];
                sendByte(frameWords[w][k*8 +: 8]);
            end
        sendByte(zeroCsum ? 8'h00 : x);
        in_valid = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_hold", {31'd0, core_hold}, 32'd1);
        check("rst_done_err_wr", {29'd0, done, err, wr}, 32'd0);
        check("rst_count", {23'd0, word_count}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        frameWords[0] = 32'h11223344;
        frameWords[1] = 32'h55667788;
        runFrame(2, 8'h02, 1'b0);
        check("good_writes", wrCount - base, 2);
        check("good_addr0", logAddr[base % 512], 32'h0);
        check("good_data0", logData[base % 512], 32'h11223344);
        check("good_addr1", logAddr[(base + 1) % 512], 32'h4);
        check("good_data1", logData[(base + 1) % 512], 32'h55667788);
        check("good_done_err", {30'd0, done, err}, 32'b10);
        check("good_hold", {31'd0, core_hold}, 32'd0);
        check("good_count", {23'd0, word_count}, 32'd2);
        check("good_stalls", stalls, 2);
        check("fetch_pc0", mem[0], 32'h11223344);

        #2 reset = 1'b0;
        #1;
        check("async_rst_hold", {31'd0, core_hold}, 32'd1);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_count", {23'd0, word_count}, 32'd0);
        check("async_rst_addr", writeAddr, 32'd0);
        check("async_rst_data", writeData, 32'd0);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        runFrame(2, 8'h02, 1'b1);
        check("bad_writes", wrCount - base, 2);
        check("bad_data1", logData[(base + 1) % 512], 32'h55667788);
        check("bad_done_err", {30'd0, done, err}, 32'b11);
        check("bad_hold", {31'd0, core_hold}, 32'd1);
        pulseStart();
        check("restart_err_done", {30'd0, done, err}, 32'b00);
        check("restart_count", {23'd0, word_count}, 32'd0);
        check("restart_ready", {31'd0, in_ready}, 32'd1);
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) frameWords[i] = i;
        runFrame(256, 8'h00, 1'b0);
        begin
            int errs;
            errs = 0;
            for (int i = 0; i < 256; i++)
                if (logAddr[(base + i) % 512] !== 32'(i * 4) || logData[(base + i) % 512] !== 32'(i)) errs++;
            check("full_stream_errs", errs, 0);
        end
        check("full_writes", wrCount - base, 256);
        check("full_last_addr", logAddr[(base + 255) % 512], 32'h3FC);
        check("full_count", {23'd0, word_count}, 32'd256);
        check("full_stalls", stalls, 256);
        check("full_done_err", {30'd0, done, err}, 32'b10);

        frameWords[0] = 32'h01020304;
        frameWords[1] = 32'h05060708;
        in_valid = 1'b1;
        pulseStart();
        sendByte(8'h02);
        for (int k = 3; k >= 0; k--) sendByte(frameWords[0][k*8 +: 8]);
        sendByte(8'h05);
        sendByte(8'h06);
        check("mid_wr_written", wrCount - base, 257);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_wr", {31'd0, wr}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_hold", {31'd0, core_hold}, 32'd1);
        #1 reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_idle_ready", {31'd0, in_ready}, 32'd0);

        frameWords[0] = 32'hDEADBEEF;
        runFrame(1, 8'h01, 1'b0);
        check("fresh_writes", wrCount - base, 1);
        check("fresh_addr", logAddr[base % 512], 32'h0);
        check("fresh_data", logData[base % 512], 32'hDEADBEEF);
        check("fresh_done_err", {30'd0, done, err}, 32'b10);
        check("fresh_hold", {31'd0, core_hold}, 32'd0);
        check("fresh_mem0", mem[0], 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
